// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: field widths, opcode/funct encodings, instruction
// classification and source-operand usage helpers.
package decode_stage_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;
  localparam int REG_RA       = 31;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = 6'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL   = 6'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_BNE   = 6'h05;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU = 6'h09;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTIU = 6'h0B;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;
  localparam logic [OPCODE_WIDTH-1:0] OP_XORI  = 6'h0E;
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = 6'h0F;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 6'h2B;

  localparam logic [FUNCT_WIDTH-1:0] FN_SLL  = 6'h00;
  localparam logic [FUNCT_WIDTH-1:0] FN_SRL  = 6'h02;
  localparam logic [FUNCT_WIDTH-1:0] FN_SRA  = 6'h03;
  localparam logic [FUNCT_WIDTH-1:0] FN_JR   = 6'h08;
  localparam logic [FUNCT_WIDTH-1:0] FN_ADD  = 6'h20;
  localparam logic [FUNCT_WIDTH-1:0] FN_ADDU = 6'h21;
  localparam logic [FUNCT_WIDTH-1:0] FN_SUB  = 6'h22;
  localparam logic [FUNCT_WIDTH-1:0] FN_SUBU = 6'h23;
  localparam logic [FUNCT_WIDTH-1:0] FN_AND  = 6'h24;
  localparam logic [FUNCT_WIDTH-1:0] FN_OR   = 6'h25;
  localparam logic [FUNCT_WIDTH-1:0] FN_XOR  = 6'h26;
  localparam logic [FUNCT_WIDTH-1:0] FN_NOR  = 6'h27;
  localparam logic [FUNCT_WIDTH-1:0] FN_SLT  = 6'h2A;
  localparam logic [FUNCT_WIDTH-1:0] FN_SLTU = 6'h2B;

  typedef enum logic [2:0] {
    CLS_ILLEGAL, CLS_RTYPE, CLS_IALU, CLS_LUI,
    CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JUMP
  } op_class_e;

  function automatic logic funct_known(input logic [FUNCT_WIDTH-1:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
      FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_shift(input logic [FUNCT_WIDTH-1:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

  function automatic op_class_e classify(input logic [OPCODE_WIDTH-1:0] op,
                                         input logic [FUNCT_WIDTH-1:0]  fn);
    case (op)
      OP_RTYPE:                     return funct_known(fn) ? CLS_RTYPE : CLS_ILLEGAL;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI:     return CLS_IALU;
      OP_LUI:                       return CLS_LUI;
      OP_LOAD:                      return CLS_LOAD;
      OP_STORE:                     return CLS_STORE;
      OP_BEQ, OP_BNE:               return CLS_BRANCH;
      OP_J, OP_JAL:                 return CLS_JUMP;
      default:                      return CLS_ILLEGAL;
    endcase
  endfunction

  // Shifts take their operand from rt; rs is a real source everywhere else it is encoded.
  function automatic logic uses_rs(input op_class_e cls, input logic [FUNCT_WIDTH-1:0] fn);
    case (cls)
      CLS_RTYPE:                                  return !is_shift(fn);
      CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH:  return 1'b1;
      default:                                    return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rt_src(input op_class_e cls, input logic [FUNCT_WIDTH-1:0] fn);
    case (cls)
      CLS_RTYPE:              return fn != FN_JR;
      CLS_STORE, CLS_BRANCH:  return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_ext.sv
// Immediate extender: sign, zero or upper-half placement of the raw immediate
// according to the opcode; zero for opcodes that carry no immediate.
module decode_imm_ext
  import decode_stage_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  input  logic [IMM_WIDTH-1:0]    i_imm,
  output logic [DWIDTH-1:0]       o_imm
);

  logic [DWIDTH-1:0] w_sext;
  logic [DWIDTH-1:0] w_zext;

  assign w_sext = {{(DWIDTH-IMM_WIDTH){i_imm[IMM_WIDTH-1]}}, i_imm};
  assign w_zext = {{(DWIDTH-IMM_WIDTH){1'b0}}, i_imm};

  always_comb begin
    case (i_opcode)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LOAD, OP_STORE, OP_BEQ, OP_BNE:    o_imm = w_sext;
      OP_ANDI, OP_ORI, OP_XORI:             o_imm = w_zext;
      OP_LUI:                               o_imm = w_zext << IMM_WIDTH;
      default:                              o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered MIPS ID stage with valid/ready handshake and flush.
// Define DECODE_HAZARD_EN to stall a consumer directly behind a load.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int AWIDTH    = 5,
  parameter int IWIDTH    = 32,
  parameter int DWIDTH    = 32,
  parameter int IMM_WIDTH = 16,
  parameter int PC_WIDTH  = 32
) (
  input  logic                    d_clk,
  input  logic                    d_rst,
  input  logic                    d_i_valid,
  output logic                    d_o_ready,
  input  logic [IWIDTH-1:0]       d_i_instr,
  input  logic [PC_WIDTH-1:0]     d_i_pc,
  input  logic                    d_i_flush,
  output logic                    d_o_valid,
  input  logic                    d_i_ready,
  output logic [OPCODE_WIDTH-1:0] d_o_opcode,
  output logic [FUNCT_WIDTH-1:0]  d_o_funct,
  output logic [AWIDTH-1:0]       d_o_addr_rs,
  output logic [AWIDTH-1:0]       d_o_addr_rt,
  output logic [AWIDTH-1:0]       d_o_addr_rd,
  output logic [4:0]              d_o_shamt,
  output logic [DWIDTH-1:0]       d_o_imm,
  output logic [25:0]             d_o_jaddr,
  output logic                    d_o_wr_en,
  output logic [AWIDTH-1:0]       d_o_wr_addr,
  output logic [PC_WIDTH-1:0]     d_o_pc,
  output logic                    d_o_illegal
);

  logic [OPCODE_WIDTH-1:0] w_op;
  logic [FUNCT_WIDTH-1:0]  w_fn;
  logic [AWIDTH-1:0]       w_rs, w_rt, w_rd;
  logic [IMM_WIDTH-1:0]    w_raw_imm;
  logic [DWIDTH-1:0]       w_imm;
  op_class_e               w_cls;

  assign w_op      = d_i_instr[IWIDTH-1 -: OPCODE_WIDTH];
  assign w_fn      = d_i_instr[FUNCT_WIDTH-1:0];
  assign w_rs      = d_i_instr[21 +: AWIDTH];
  assign w_rt      = d_i_instr[16 +: AWIDTH];
  assign w_rd      = d_i_instr[11 +: AWIDTH];
  assign w_raw_imm = d_i_instr[IMM_WIDTH-1:0];
  assign w_cls     = classify(w_op, w_fn);

  decode_imm_ext #(.DWIDTH(DWIDTH), .IMM_WIDTH(IMM_WIDTH)) u_imm_ext (
    .i_opcode (w_op),
    .i_imm    (w_raw_imm),
    .o_imm    (w_imm)
  );

  logic [FUNCT_WIDTH-1:0] w_d_funct;
  logic [AWIDTH-1:0]      w_d_rs, w_d_rt, w_d_rd, w_d_wr_addr;
  logic [4:0]             w_d_shamt;
  logic [25:0]            w_d_jaddr;
  logic                   w_d_writes, w_d_wr_en, w_d_illegal;

  // Fields a class does not use are forced to 0; an illegal word keeps only opcode/funct.
  always_comb begin
    w_d_funct   = '0;
    w_d_rs      = '0;
    w_d_rt      = '0;
    w_d_rd      = '0;
    w_d_shamt   = '0;
    w_d_jaddr   = '0;
    w_d_wr_addr = '0;
    w_d_writes  = 1'b0;
    w_d_illegal = 1'b0;
    case (w_cls)
      CLS_RTYPE: begin
        w_d_funct = w_fn;
        w_d_shamt = d_i_instr[10:6];
        w_d_rs    = uses_rs(w_cls, w_fn) ? w_rs : '0;
        if (w_fn != FN_JR) begin
          w_d_rt      = w_rt;
          w_d_rd      = w_rd;
          w_d_wr_addr = w_rd;
          w_d_writes  = 1'b1;
        end
      end
      CLS_IALU, CLS_LOAD: begin
        w_d_rs      = w_rs;
        w_d_rt      = w_rt;
        w_d_wr_addr = w_rt;
        w_d_writes  = 1'b1;
      end
      CLS_LUI: begin
        w_d_rt      = w_rt;
        w_d_wr_addr = w_rt;
        w_d_writes  = 1'b1;
      end
      CLS_STORE, CLS_BRANCH: begin
        w_d_rs = w_rs;
        w_d_rt = w_rt;
      end
      CLS_JUMP: begin
        w_d_jaddr = d_i_instr[25:0];
        if (w_op == OP_JAL) begin
          w_d_wr_addr = AWIDTH'(REG_RA);
          w_d_writes  = 1'b1;
        end
      end
      default: begin
        w_d_funct   = w_fn;
        w_d_illegal = 1'b1;
      end
    endcase
  end

  assign w_d_wr_en = w_d_writes && (w_d_wr_addr != '0);

  logic                    r_valid;
  logic [OPCODE_WIDTH-1:0] r_opcode;
  logic [FUNCT_WIDTH-1:0]  r_funct;
  logic [AWIDTH-1:0]       r_rs, r_rt, r_rd, r_wr_addr;
  logic [4:0]              r_shamt;
  logic [DWIDTH-1:0]       r_imm;
  logic [25:0]             r_jaddr;
  logic                    r_wr_en, r_illegal;
  logic [PC_WIDTH-1:0]     r_pc;
  logic                    w_hazard, w_accept;

`ifdef DECODE_HAZARD_EN
  logic w_use_rs, w_use_rt;
  assign w_use_rs = uses_rs(w_cls, w_fn);
  assign w_use_rt = uses_rt_src(w_cls, w_fn);
  assign w_hazard = r_valid && (r_opcode == OP_LOAD) && (r_wr_addr != '0) &&
                    ((w_use_rs && (w_rs == r_wr_addr)) || (w_use_rt && (w_rt == r_wr_addr)));
`else
  assign w_hazard = 1'b0;
`endif

  assign d_o_ready = (!r_valid || d_i_ready) && !w_hazard;
  assign w_accept  = d_i_valid && d_o_ready;

  // Output register: flush beats accept, accept beats drain, otherwise hold.
  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      r_valid   <= 1'b0;
      r_opcode  <= '0;
      r_funct   <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_shamt   <= '0;
      r_imm     <= '0;
      r_jaddr   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_pc      <= '0;
      r_illegal <= 1'b0;
    end else if (d_i_flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_opcode  <= w_op;
      r_funct   <= w_d_funct;
      r_rs      <= w_d_rs;
      r_rt      <= w_d_rt;
      r_rd      <= w_d_rd;
      r_shamt   <= w_d_shamt;
      r_imm     <= w_imm;
      r_jaddr   <= w_d_jaddr;
      r_wr_en   <= w_d_wr_en;
      r_wr_addr <= w_d_wr_addr;
      r_pc      <= d_i_pc;
      r_illegal <= w_d_illegal;
    end else if (d_i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign d_o_valid   = r_valid;
  assign d_o_opcode  = r_opcode;
  assign d_o_funct   = r_funct;
  assign d_o_addr_rs = r_rs;
  assign d_o_addr_rt = r_rt;
  assign d_o_addr_rd = r_rd;
  assign d_o_shamt   = r_shamt;
  assign d_o_imm     = r_imm;
  assign d_o_jaddr   = r_jaddr;
  assign d_o_wr_en   = r_wr_en;
  assign d_o_wr_addr = r_wr_addr;
  assign d_o_pc      = r_pc;
  assign d_o_illegal = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases then randomized traffic
// against a cycle-level reference model of the decode rules and handshake.
module tb_decode_stage;

`ifdef DECODE_HAZARD_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        d_clk = 1'b0;
  logic        d_rst = 1'b0;
  logic        d_i_valid = 1'b0, d_i_flush = 1'b0, d_i_ready = 1'b0;
  logic [31:0] d_i_instr = '0, d_i_pc = '0;
  logic        d_o_ready, d_o_valid, d_o_wr_en, d_o_illegal;
  logic [5:0]  d_o_opcode, d_o_funct;
  logic [4:0]  d_o_addr_rs, d_o_addr_rt, d_o_addr_rd, d_o_shamt, d_o_wr_addr;
  logic [31:0] d_o_imm, d_o_pc;
  logic [25:0] d_o_jaddr;

  always #5 d_clk = ~d_clk;

  decode_stage dut (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_valid(d_i_valid), .d_o_ready(d_o_ready),
    .d_i_instr(d_i_instr), .d_i_pc(d_i_pc), .d_i_flush(d_i_flush),
    .d_o_valid(d_o_valid), .d_i_ready(d_i_ready), .d_o_opcode(d_o_opcode),
    .d_o_funct(d_o_funct), .d_o_addr_rs(d_o_addr_rs), .d_o_addr_rt(d_o_addr_rt),
    .d_o_addr_rd(d_o_addr_rd), .d_o_shamt(d_o_shamt), .d_o_imm(d_o_imm),
    .d_o_jaddr(d_o_jaddr), .d_o_wr_en(d_o_wr_en), .d_o_wr_addr(d_o_wr_addr),
    .d_o_pc(d_o_pc), .d_o_illegal(d_o_illegal)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] imm;
    logic [25:0] ja;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] pc;
    logic        ill;
  } bundle_t;

  logic [128:0] w_obs;
  assign w_obs = {d_o_opcode, d_o_funct, d_o_addr_rs, d_o_addr_rt, d_o_addr_rd, d_o_shamt,
                  d_o_imm, d_o_jaddr, d_o_wr_en, d_o_wr_addr, d_o_pc, d_o_illegal};

  int      n_chk = 0;
  int      n_fail = 0;
  logic    exp_valid = 1'b0;
  bundle_t exp_b = '0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decode rules stated directly: which fields an instruction carries, where it writes,
  // how its immediate extends, and which registers it reads.
  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         output logic urs, output logic urt);
    bundle_t b;
    logic [5:0]  op, fn;
    logic [15:0] i16;
    int dst, ext;
    op = ins[31:26]; fn = ins[5:0]; i16 = ins[15:0];
    b = '0; b.op = op; b.pc = pc;
    urs = 0; urt = 0; dst = -1; ext = 0;
    if (op == 6'h00) begin
      b.fn = fn;
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h08, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
        b.sh = ins[10:6];
        if (fn == 6'h08) begin
          b.rs = ins[25:21]; urs = 1;
        end else begin
          if (!(fn inside {6'h00, 6'h02, 6'h03})) begin b.rs = ins[25:21]; urs = 1; end
          b.rt = ins[20:16]; urt = 1;
          b.rd = ins[15:11]; dst = int'(ins[15:11]);
        end
      end else b.ill = 1;
    end else if (op inside {[6'h08:6'h0E], 6'h23}) begin
      b.rs = ins[25:21]; b.rt = ins[20:16]; urs = 1; dst = int'(ins[20:16]);
      ext = (op inside {6'h0C, 6'h0D, 6'h0E}) ? 2 : 1;
    end else if (op == 6'h0F) begin
      b.rt = ins[20:16]; dst = int'(ins[20:16]); ext = 3;
    end else if (op inside {6'h2B, 6'h04, 6'h05}) begin
      b.rs = ins[25:21]; b.rt = ins[20:16]; urs = 1; urt = 1; ext = 1;
    end else if (op == 6'h02 || op == 6'h03) begin
      b.ja = ins[25:0];
      if (op == 6'h03) dst = 31;
    end else begin
      b.fn = fn; b.ill = 1;
    end
    case (ext)
      1: b.imm = (i16 >= 16'h8000) ? 32'(i16) + 32'hFFFF_0000 : 32'(i16);
      2: b.imm = 32'(i16);
      3: b.imm = 32'(i16) * 32'd65536;
      default: b.imm = 0;
    endcase
    if (dst > 0) begin b.we = 1; b.wa = 5'(dst); end
    return b;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic rdy);
    bundle_t nb;
    logic urs, urt, hz, mrdy;
    @(negedge d_clk);
    d_i_valid = v; d_i_instr = ins; d_i_pc = pc; d_i_flush = fl; d_i_ready = rdy;
    #1;
    nb = ref_decode(ins, pc, urs, urt);
    hz = HZ && exp_valid && exp_b.op == 6'h23 && exp_b.wa != 0 &&
         ((urs && ins[25:21] == exp_b.wa) || (urt && ins[20:16] == exp_b.wa));
    mrdy = (!exp_valid || rdy) && !hz;
    check("ready", d_o_ready, mrdy);
    check("valid", d_o_valid, exp_valid);
    check("bundle", w_obs, exp_b);
    @(posedge d_clk);
    if (fl) exp_valid = 0;
    else if (v && mrdy) begin exp_valid = 1; exp_b = nb; end
    else if (rdy) exp_valid = 0;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops[20] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                            6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B, 6'h3F, 6'h01};
    logic [5:0] fns[16] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
                            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01, 6'h3F};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 19)];
    if ($urandom_range(0, 3) != 0) begin
      w[25:21] = 5'($urandom_range(0, 3));
      w[20:16] = 5'($urandom_range(0, 3));
    end
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 15)];
    return w;
  endfunction

  initial begin
    repeat (3) @(posedge d_clk);
    #1;
    check("rst_valid", d_o_valid, 0);
    check("rst_ready", d_o_ready, 1);
    check("rst_bundle", w_obs, 0);
    @(negedge d_clk);
    d_rst = 1'b1;

    cycle(1, 32'h0022_1820, 32'h100, 0, 1);
    check("add_rs", d_o_addr_rs, 1);
    check("add_rt", d_o_addr_rt, 2);
    check("add_rd", d_o_addr_rd, 3);
    check("add_funct", d_o_funct, 6'h20);
    check("add_wr", {d_o_wr_en, d_o_wr_addr}, {1'b1, 5'd3});
    check("add_imm", d_o_imm, 0);
    cycle(1, 32'h2005_FFFF, 32'h104, 0, 1);
    check("addi_imm", d_o_imm, 32'hFFFF_FFFF);
    check("addi_wa", d_o_wr_addr, 5);
    cycle(1, 32'h30A5_FFFF, 32'h108, 0, 1);
    check("andi_imm", d_o_imm, 32'h0000_FFFF);
    cycle(1, 32'h3C05_1234, 32'h10C, 0, 1);
    check("lui_imm", d_o_imm, 32'h1234_0000);

    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h0022_1820, 32'h114, 0, 0);
      check("bp_valid", d_o_valid, 1);
      check("bp_hold", {d_o_imm, d_o_pc}, {32'h1234_0000, 32'h10C});
    end
    cycle(1, 32'h0022_1820, 32'h114, 0, 1);
    check("bp_next", {d_o_valid, d_o_pc, d_o_addr_rd}, {1'b1, 32'h114, 5'd3});

    cycle(1, 32'h2005_FFFF, 32'h118, 0, 0);
    cycle(1, 32'h3C05_1234, 32'h11C, 1, 0);
    check("flush_valid", d_o_valid, 0);
    cycle(0, 32'h0, 32'h0, 0, 1);
    check("flush_drop", {d_o_valid, d_o_pc}, {1'b0, 32'h114});

    cycle(1, 32'h0C00_0010, 32'h120, 0, 1);
    check("jal", {d_o_jaddr, d_o_wr_en, d_o_wr_addr}, {26'h10, 1'b1, 5'd31});
    cycle(1, 32'hFC00_0000, 32'h124, 0, 1);
    check("illegal", {d_o_valid, d_o_illegal, d_o_wr_en, d_o_opcode}, {3'b110, 6'h3F});

    cycle(1, 32'h8C22_0000, 32'h130, 0, 1);
    cycle(1, 32'h0042_1820, 32'h134, 0, 1);
    check("ld_use_first", {d_o_valid, d_o_pc}, HZ ? {1'b0, 32'h130} : {1'b1, 32'h134});
    cycle(1, 32'h0042_1820, 32'h134, 0, 1);
    check("ld_use_after", {d_o_valid, d_o_pc}, {1'b1, 32'h134});
    cycle(1, 32'h8C20_0000, 32'h140, 0, 1);
    cycle(1, 32'h0000_1820, 32'h144, 0, 1);
    check("ld_zero", {d_o_valid, d_o_pc}, {1'b1, 32'h144});

    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
